// File: rtl/anita4_l0_scaler_counter_pkg.sv
// Purpose: shared constants for the L0 scaler counter slice (default sizes, readout address width, reference-pulse line).
// Latency: n/a (package only).
// Backpressure: n/a.
package anita4_l0_scaler_counter_pkg;

    // Default geometry of the scaler bank.
    localparam int          NCH_DEF      = 32;
    localparam int          CNT_W_DEF    = 16;
    localparam int unsigned PERIOD_DEF   = 32'd33333333;  // 1 s gate at 33.33 MHz

    // Scaler line carrying the registered reference pulse from the trigger processor.
    localparam int          REF_PULSE_CH = 21;

    // Readout address width (covers all NCH_DEF channels).
    localparam int          ADDR_W       = 5;

    // Period counter width; PERIOD may be as large as 2^32-1.
    localparam int          PCNT_W       = 32;

endpackage

// File: rtl/anita4_l0_scaler_counter_if.sv
// Purpose: housekeeping read port of the scaler holding bank (strobe + address in, data + ack out).
// Latency: dat/ack valid one cycle after rd.
// Backpressure: none; the slave accepts a read every cycle.
interface anita4_l0_scaler_counter_if
    import anita4_l0_scaler_counter_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic              rd;    // one-cycle read strobe
    logic [ADDR_W-1:0] addr;  // channel to read
    logic [CNT_W-1:0]  dat;   // read data, held between acks
    logic              ack;   // read data valid, one cycle

    modport master (output rd, addr, input dat, ack);
    modport slave  (input rd, addr, output dat, ack);
endinterface

// File: rtl/anita4_scaler_channel.sv
// Purpose: one scaler line -- rising-edge detect, saturating gate accumulator, holding register and saturation flag.
// Latency: an edge in cycle n lands in the accumulator at the edge ending cycle n; hold updates at the edge ending the terminal cycle.
// Backpressure: none; every input cycle is consumed.
// Ports: clk_i/rst_n_i clock and async active-low reset; scal_i scaler line; en_i counting enable;
//        tc_i gate terminal-count cycle; hold_o latched count of the last gate; sat_o that count saturated.
module anita4_scaler_channel #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             scal_i,
    input  logic             en_i,
    input  logic             tc_i,
    output logic [CNT_W-1:0] hold_o,
    output logic             sat_o
);
    logic             prev_q;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic             acc_sat_q, acc_sat_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             sat_q, sat_d;
    logic             rise;
    logic             at_max;

    always_comb begin
        rise      = scal_i & ~prev_q;
        at_max    = &acc_q;
        acc_d     = acc_q;
        acc_sat_d = acc_sat_q;
        hold_d    = hold_q;
        sat_d     = sat_q;
        if (!en_i) begin
            acc_d     = '0;
            acc_sat_d = 1'b0;
        end else if (tc_i) begin
            // The terminal-cycle edge belongs to the closing gate, so fold it
            // into the latched value rather than into the fresh accumulator.
            hold_d    = at_max ? acc_q : acc_q + CNT_W'(rise);
            sat_d     = acc_sat_q | (rise & at_max);
            acc_d     = '0;
            acc_sat_d = 1'b0;
        end else if (rise) begin
            // Saturation means an edge was lost: the counter is pinned at max.
            if (at_max) begin
                acc_sat_d = 1'b1;
            end else begin
                acc_d = acc_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            prev_q    <= 1'b1;  // a line held high through reset must not count
            acc_q     <= '0;
            acc_sat_q <= 1'b0;
            hold_q    <= '0;
            sat_q     <= 1'b0;
        end else begin
            prev_q    <= scal_i;
            acc_q     <= acc_d;
            acc_sat_q <= acc_sat_d;
            hold_q    <= hold_d;
            sat_q     <= sat_d;
        end
    end

    assign hold_o = hold_q;
    assign sat_o  = sat_q;
endmodule

// File: rtl/anita4_l0_scaler_counter.sv
// Purpose: counts rising edges on NCH scaler lines per PERIOD-cycle gate, latches them into a holding bank, serves the bank on a read port.
// Latency: read data one cycle after rd; new_o high the cycle after the gate's terminal cycle.
// Backpressure: none; reads accepted every cycle, back-to-back reads give back-to-back acks.
// Ports: mclk_i/rst_n_i clock and async active-low reset; scal_i scaler lines; en_i counting enable;
//        clr_new_i clears new_o; sat_o per-channel saturation of the holding bank; new_o bank updated;
//        rd_bus read port (rd/addr in, dat/ack out).
module anita4_l0_scaler_counter
    import anita4_l0_scaler_counter_pkg::*;
#(
    parameter int          NCH    = NCH_DEF,
    parameter int          CNT_W  = CNT_W_DEF,
    parameter int unsigned PERIOD = PERIOD_DEF
) (
    input  logic                        mclk_i,
    input  logic                        rst_n_i,
    input  logic [NCH-1:0]              scal_i,
    input  logic                        en_i,
    input  logic                        clr_new_i,
    output logic [NCH-1:0]              sat_o,
    output logic                        new_o,
    anita4_l0_scaler_counter_if.slave   rd_bus
);
    logic [PCNT_W-1:0] cnt_q, cnt_d;
    logic              tc;
    logic              new_q;
    logic [CNT_W-1:0]  dat_q;
    logic              ack_q;
    logic [CNT_W-1:0]  hold_w [NCH];

    // Gate timer: held at zero while disabled, so re-enabling starts a full gate.
    always_comb begin
        tc    = en_i && (cnt_q == PCNT_W'(PERIOD - 1));
        cnt_d = cnt_q + PCNT_W'(1);
        if (!en_i || tc) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge mclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
            new_q <= 1'b0;
            dat_q <= '0;
            ack_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            // A latch in the same cycle as a clear leaves new_o set.
            if (tc) begin
                new_q <= 1'b1;
            end else if (clr_new_i) begin
                new_q <= 1'b0;
            end
            // The bank is sampled before this edge's latch, so a read that
            // coincides with the terminal cycle returns the previous gate.
            ack_q <= rd_bus.rd;
            if (rd_bus.rd) begin
                dat_q <= (32'(rd_bus.addr) < NCH) ? hold_w[rd_bus.addr] : '0;
            end
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        anita4_scaler_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk_i   (mclk_i),
            .rst_n_i (rst_n_i),
            .scal_i  (scal_i[k]),
            .en_i    (en_i),
            .tc_i    (tc),
            .hold_o  (hold_w[k]),
            .sat_o   (sat_o[k])
        );
    end

    assign new_o      = new_q;
    assign rd_bus.dat = dat_q;
    assign rd_bus.ack = ack_q;
endmodule
